round_sequencer: RTL and testbench

ROUND_SEQUENCER -- requirements
Module: round_sequencer

---
 rtl/game_pkg.sv | 22 ++
 rtl/sec_tick_gen.sv | 47 ++++
 rtl/round_sequencer.sv | 166 ++++++++++++++++
 tb/tb_round_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg
// Definitions shared by the game blocks: the round-state encoding seen on the
// sequencer's state port, default countdown and round lengths, and a helper
// that identifies the states in which game time is counted.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_PLAY      = 2'd2,
        ST_GAME_OVER = 2'd3
    } game_state_e;

    localparam int DEF_COUNT_SECONDS = 3;
    localparam int DEF_ROUND_SECONDS = 60;

    // True for the states in which the second timer runs.
    function automatic logic is_timed(input game_state_e s);
        return (s == ST_COUNTDOWN) || (s == ST_PLAY);
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// sec_tick_gen
// Game-second timer. The counter runs 0..TICKS_PER_SEC-1 while enable is high
// and holds its value while enable is low. one_sec marks the last cycle of a
// game second.
// Ports:
//   clock   - system clock, rising edge
//   reset   - asynchronous, active-high
//   enable  - count this cycle
//   clear   - force the count back to 0 (takes priority over enable)
//   one_sec - high on the enabled terminal-count cycle
module sec_tick_gen #(
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic one_sec
);

    localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] TERMINAL = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_terminal;

    assign at_terminal = (cnt_q == TERMINAL);
    assign one_sec     = enable && at_terminal;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = at_terminal ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/round_sequencer.sv
// round_sequencer
// Round sequencer for the game: IDLE -> COUNTDOWN -> PLAY -> GAME_OVER, with
// a second timer that can be paused and an abort that returns to idle.
//
//   state         | meaning
//   --------------+----------------------------------------------------
//   ST_IDLE       | waiting for start; all outputs low
//   ST_COUNTDOWN  | pre-round countdown, counts COUNT_SECONDS down to 1
//   ST_PLAY       | round in progress, seconds_left counts down to 1
//   ST_GAME_OVER  | round finished; game_over held until start or abort
//
// Ports:
//   clock, reset       - system clock; asynchronous active-high reset
//   start, abort       - single-cycle request pulses (abort wins)
//   pause              - level input; freezes timing in COUNTDOWN/PLAY
//   state              - current state encoding
//   clear_scores       - one-cycle pulse when a round is launched
//   play_active        - PLAY and not paused
//   game_over          - high throughout GAME_OVER
//   countdown          - seconds remaining in COUNTDOWN, else 0
//   seconds_left       - seconds remaining in PLAY, else 0
//   paused             - pause seen while in COUNTDOWN or PLAY
// All outputs are registered.
module round_sequencer
    import game_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int COUNT_SECONDS = DEF_COUNT_SECONDS,
    parameter int ROUND_SECONDS = DEF_ROUND_SECONDS
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       pause,
    output logic [1:0] state,
    output logic       clear_scores,
    output logic       play_active,
    output logic       game_over,
    output logic [1:0] countdown,
    output logic [6:0] seconds_left,
    output logic       paused
);

    localparam logic [1:0] CD_INIT    = 2'(COUNT_SECONDS);
    localparam logic [6:0] ROUND_INIT = 7'(ROUND_SECONDS);

    game_state_e state_q, state_d;
    logic [1:0]  countdown_q, countdown_d;
    logic [6:0]  seconds_left_q, seconds_left_d;
    logic        clear_scores_q, clear_scores_d;
    logic        play_active_q, play_active_d;
    logic        game_over_q, game_over_d;
    logic        paused_q, paused_d;

    logic tick_en;
    logic tick_clr;
    logic one_sec;

    assign tick_en = is_timed(state_q) && !pause;
    // Every state change restarts the game second; an abort always clears,
    // which also covers an abort arriving while already idle.
    assign tick_clr = abort || (state_d != state_q);

    sec_tick_gen #(
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_sec_tick_gen (
        .clock   (clock),
        .reset   (reset),
        .enable  (tick_en),
        .clear   (tick_clr),
        .one_sec (one_sec)
    );

    always_comb begin
        state_d        = state_q;
        countdown_d    = countdown_q;
        seconds_left_d = seconds_left_q;
        clear_scores_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d        = ST_COUNTDOWN;
                    countdown_d    = CD_INIT;
                    clear_scores_d = 1'b1;
                end
            end
            ST_COUNTDOWN: begin
                if (one_sec) begin
                    // <= 1 also catches a zero count, so the counter never wraps.
                    if (countdown_q <= 2'd1) begin
                        state_d        = ST_PLAY;
                        countdown_d    = 2'd0;
                        seconds_left_d = ROUND_INIT;
                    end else begin
                        countdown_d = countdown_q - 2'd1;
                    end
                end
            end
            ST_PLAY: begin
                if (one_sec) begin
                    if (seconds_left_q <= 7'd1) begin
                        state_d        = ST_GAME_OVER;
                        seconds_left_d = 7'd0;
                    end else begin
                        seconds_left_d = seconds_left_q - 7'd1;
                    end
                end
            end
            ST_GAME_OVER: begin
                if (start) begin
                    state_d        = ST_COUNTDOWN;
                    countdown_d    = CD_INIT;
                    seconds_left_d = 7'd0;
                    clear_scores_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d        = ST_IDLE;
            countdown_d    = 2'd0;
            seconds_left_d = 7'd0;
            clear_scores_d = 1'b0;
        end

        // Level outputs follow the state being entered so that they line up
        // with the registered state one clock after the cause.
        game_over_d   = (state_d == ST_GAME_OVER);
        play_active_d = (state_d == ST_PLAY) && !pause;
        paused_d      = is_timed(state_d) && pause;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            countdown_q    <= 2'd0;
            seconds_left_q <= 7'd0;
            clear_scores_q <= 1'b0;
            play_active_q  <= 1'b0;
            game_over_q    <= 1'b0;
            paused_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            countdown_q    <= countdown_d;
            seconds_left_q <= seconds_left_d;
            clear_scores_q <= clear_scores_d;
            play_active_q  <= play_active_d;
            game_over_q    <= game_over_d;
            paused_q       <= paused_d;
        end
    end

    assign state        = state_q;
    assign clear_scores = clear_scores_q;
    assign play_active  = play_active_q;
    assign game_over    = game_over_q;
    assign countdown    = countdown_q;
    assign seconds_left = seconds_left_q;
    assign paused       = paused_q;

endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer
// Directed bench for round_sequencer with TICKS_PER_SEC=4, COUNT_SECONDS=3,
// ROUND_SECONDS=5. Expected output values are queued as stimulus is applied
// and compared once the DUT has responded.
module tb_round_sequencer;

    localparam int TPS = 4;
    localparam int CS  = 3;
    localparam int RS  = 5;

    localparam int SIG_STATE = 0;
    localparam int SIG_CLEAR = 1;
    localparam int SIG_CD    = 2;
    localparam int SIG_SECS  = 3;
    localparam int SIG_PLAY  = 4;
    localparam int SIG_GO    = 5;
    localparam int SIG_PAUSE = 6;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       start;
    logic       abort;
    logic       pause;
    logic [1:0] state_o;
    logic       clear_scores_o;
    logic       play_active_o;
    logic       game_over_o;
    logic [1:0] countdown_o;
    logic [6:0] seconds_left_o;
    logic       paused_o;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    round_sequencer #(
        .TICKS_PER_SEC (TPS),
        .COUNT_SECONDS (CS),
        .ROUND_SECONDS (RS)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .pause        (pause),
        .state        (state_o),
        .clear_scores (clear_scores_o),
        .play_active  (play_active_o),
        .game_over    (game_over_o),
        .countdown    (countdown_o),
        .seconds_left (seconds_left_o),
        .paused       (paused_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] obs(input int sig);
        logic [31:0] v;
        v = 'x;
        case (sig)
            SIG_STATE: v = {30'd0, state_o};
            SIG_CLEAR: v = {31'd0, clear_scores_o};
            SIG_CD:    v = {30'd0, countdown_o};
            SIG_SECS:  v = {25'd0, seconds_left_o};
            SIG_PLAY:  v = {31'd0, play_active_o};
            SIG_GO:    v = {31'd0, game_over_o};
            SIG_PAUSE: v = {31'd0, paused_o};
            default:   v = 'x;
        endcase
        return v;
    endfunction

    function automatic string sig_name(input int sig);
        case (sig)
            SIG_STATE: return "state";
            SIG_CLEAR: return "clear_scores";
            SIG_CD:    return "countdown";
            SIG_SECS:  return "seconds_left";
            SIG_PLAY:  return "play_active";
            SIG_GO:    return "game_over";
            SIG_PAUSE: return "paused";
            default:   return "unknown";
        endcase
    endfunction

    task automatic push(input string tag, input int sig, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic push_all(input string tag, input int st, input int cl, input int cd,
                            input int sl, input int pa, input int go, input int ps);
        push(tag, SIG_STATE, st);
        push(tag, SIG_CLEAR, cl);
        push(tag, SIG_CD, cd);
        push(tag, SIG_SECS, sl);
        push(tag, SIG_PLAY, pa);
        push(tag, SIG_GO, go);
        push(tag, SIG_PAUSE, ps);
    endtask

    task automatic check_queue();
        exp_t        e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sig);
            checks++;
            assert (o === e.exp) else begin
                failures++;
                $error("FAIL %s.%s observed=%0d expected=%0d", e.tag, sig_name(e.sig), o, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Countdown after a launch edge: 12 edges, optional start pulse at edge start_at.
    task automatic countdown_phase(input string ph, input int start_at);
        for (int k = 1; k <= CS * TPS; k++) begin
            start = (k == start_at);
            tick();
            start = 1'b0;
            if (k < CS * TPS)
                push_all($sformatf("%s_cd%0d", ph, k), 1, 0, CS - k / TPS, 0, 0, 0, 0);
            else
                push_all($sformatf("%s_cd%0d", ph, k), 2, 0, 0, RS, 1, 0, 0);
            check_queue();
        end
    endtask

    // PLAY phase: n counts the unpaused edges, i.e. game time actually spent.
    task automatic play_phase(input string ph, input int start_at, input int pz_from,
                              input int pz_to, input int go_at);
        int n;
        bit pz;
        n = 0;
        for (int p = 1; p <= go_at; p++) begin
            pz = (p >= pz_from) && (p <= pz_to);
            pause = pz;
            start = (p == start_at);
            tick();
            start = 1'b0;
            if (!pz) n++;
            if (n >= RS * TPS)
                push_all($sformatf("%s_pl%0d", ph, p), 3, 0, 0, 0, 0, 1, 0);
            else
                push_all($sformatf("%s_pl%0d", ph, p), 2, 0, 0, RS - n / TPS,
                         pz ? 0 : 1, 0, pz ? 1 : 0);
            check_queue();
        end
        pause = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        pause = 1'b0;
        repeat (3) tick();
        push_all("reset", 0, 0, 0, 0, 0, 0, 0);
        check_queue();
        reset = 1'b0;
        tick();
        push_all("idle", 0, 0, 0, 0, 0, 0, 0);
        check_queue();

        // Round A: start from IDLE, uninterrupted round, GAME_OVER hold.
        start = 1'b1;
        tick();
        start = 1'b0;
        push_all("a_start", 1, 1, CS, 0, 0, 0, 0);
        check_queue();
        countdown_phase("a", 0);
        play_phase("a", 0, 1000, 0, RS * TPS);
        for (int i = 0; i < 100; i++) begin
            pause = (i >= 40) && (i < 60);
            tick();
            push($sformatf("a_hold%0d", i), SIG_GO, 1);
            push($sformatf("a_hold%0d", i), SIG_STATE, 3);
            push($sformatf("a_hold%0d", i), SIG_PAUSE, 0);
            check_queue();
        end
        pause = 1'b0;

        // Round B: restart from GAME_OVER, ignored starts, 10-cycle pause.
        start = 1'b1;
        tick();
        start = 1'b0;
        push_all("b_start", 1, 1, CS, 0, 0, 0, 0);
        check_queue();
        countdown_phase("b", 5);
        play_phase("b", 6, 10, 19, RS * TPS + 10);

        // Round C: abort together with start while in PLAY.
        start = 1'b1;
        tick();
        start = 1'b0;
        push_all("c_start", 1, 1, CS, 0, 0, 0, 0);
        check_queue();
        countdown_phase("c", 0);
        for (int p = 1; p <= 3; p++) begin
            tick();
            push_all($sformatf("c_pl%0d", p), 2, 0, 0, RS, 1, 0, 0);
            check_queue();
        end
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        push_all("c_abort", 0, 0, 0, 0, 0, 0, 0);
        check_queue();
        pause = 1'b1;
        tick();
        push_all("c_idle_pause", 0, 0, 0, 0, 0, 0, 0);
        check_queue();
        pause = 1'b0;

        // Round D: asynchronous reset in the middle of COUNTDOWN.
        start = 1'b1;
        tick();
        start = 1'b0;
        push_all("d_start", 1, 1, CS, 0, 0, 0, 0);
        check_queue();
        repeat (5) tick();
        push("d_mid", SIG_CD, CS - 5 / TPS);
        check_queue();
        #2;
        reset = 1'b1;
        #1;
        push_all("d_async_rst", 0, 0, 0, 0, 0, 0, 0);
        check_queue();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            push_all($sformatf("d_post%0d", i), 0, 0, 0, 0, 0, 0, 0);
            check_queue();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
